// File: rtl/btn_ctrl.sv
// Push-button MMIO controller: two-flop sync, debounce and press detect per button.
// Exposes read-to-clear events, debounced levels, an irq mask and saturating press counters.
module btn_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn1,
    input  logic                  btn2,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [ADDR_WIDTH-1:0] AddrEvent = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] AddrLevel = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrIrqEn = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] AddrCount = ADDR_WIDTH'(3);

    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    level_q, level_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    press;

    logic [1:0]    event_q, event_d;
    logic [1:0]    irq_en_q, irq_en_d;
    logic [15:0]   count1_q, count1_d;
    logic [15:0]   count2_q, count2_d;
    logic [31:0]   rdata, data_d;
    logic          irq_d;
    logic          sel_event, sel_irq_en, sel_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn2, btn1};
            sync2_q <= sync1_q;
        end
    end

    // The counter only runs while the synchronized sample disagrees with the stable level.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press = level_d & ~level_q;
    end

    assign sel_event  = (address == AddrEvent);
    assign sel_irq_en = (address == AddrIrqEn);
    assign sel_count  = (address == AddrCount);

    always_comb begin
        rdata = '0;
        case (address)
            AddrEvent: rdata = {30'b0, event_q};
            AddrLevel: rdata = {30'b0, level_q};
            AddrIrqEn: rdata = {30'b0, irq_en_q};
            AddrCount: rdata = {count2_q, count1_q};
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        // A press on the clearing edge survives the clear.
        event_d = (read_enable && sel_event) ? press : (event_q | press);

        irq_en_d = irq_en_q;
        if (write_enable && sel_irq_en) begin
            irq_en_d = data_in[1:0];
        end

        count1_d = count1_q;
        count2_d = count2_q;
        if (write_enable && sel_count) begin
            count1_d = '0;
            count2_d = '0;
        end else begin
            if (press[0] && (count1_q != 16'hFFFF)) count1_d = count1_q + 16'd1;
            if (press[1] && (count2_q != 16'hFFFF)) count2_d = count2_q + 16'd1;
        end

        data_d = read_enable ? rdata : data_out;
        irq_d  = |(event_d & irq_en_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            event_q  <= '0;
            irq_en_q <= '0;
            count1_q <= '0;
            count2_q <= '0;
            data_out <= '0;
            irq      <= 1'b0;
        end else begin
            level_q  <= level_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            event_q  <= event_d;
            irq_en_q <= irq_en_d;
            count1_q <= count1_d;
            count2_q <= count2_d;
            data_out <= data_d;
            irq      <= irq_d;
        end
    end

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with DEBOUNCE_CYCLES=4; expectations are hand-computed.
module tb_btn_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn1, btn2;
    logic        read_enable, write_enable;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    btn_ctrl #(
        .ADDR_WIDTH     (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn1        (btn1),
        .btn2        (btn2),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        address     = a;
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        d           = data_out;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic press(input int which, input int hold);
        @(negedge clk);
        if (which == 1) btn1 = 1'b1; else btn2 = 1'b1;
        repeat (hold) @(negedge clk);
        if (which == 1) btn1 = 1'b0; else btn2 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; btn1 = 1'b1; btn2 = 1'b0;
        read_enable = 1'b0; write_enable = 1'b0; address = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;

        // Button held through reset registers as a press.
        repeat (8) @(negedge clk);
        do_read(8'd1, rd); check("held_level", rd, 32'h1);
        do_read(8'd0, rd); check("held_event", rd, 32'h1);
        check("held_irq_masked", {31'b0, irq}, 32'h0);
        btn1 = 1'b0;
        repeat (10) @(negedge clk);
        do_read(8'd1, rd); check("release_level", rd, 32'h0);
        do_read(8'd0, rd); check("release_no_event", rd, 32'h0);
        do_write(8'd3, 32'h0);

        // Two-cycle glitch.
        press(1, 2);
        do_read(8'd0, rd); check("glitch_event", rd, 32'h0);
        do_read(8'd1, rd); check("glitch_level", rd, 32'h0);
        do_read(8'd3, rd); check("glitch_count", rd, 32'h0);

        // Clean press, read-to-clear.
        press(1, 10);
        do_read(8'd0, rd); check("press_event_1st", rd, 32'h1);
        do_read(8'd0, rd); check("press_event_2nd", rd, 32'h0);
        do_read(8'd3, rd); check("press_count", rd, 32'h1);

        // Interrupt masking.
        do_write(8'd2, 32'h2);
        press(1, 10);
        check("irq_masked_btn1", {31'b0, irq}, 32'h0);
        @(negedge clk);
        btn2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (irq) break;
            @(negedge clk);
        end
        check("irq_raised_btn2", {31'b0, irq}, 32'h1);
        btn2 = 1'b0;
        repeat (10) @(negedge clk);
        check("irq_held", {31'b0, irq}, 32'h1);
        do_read(8'd0, rd); check("irq_event_both", rd, 32'h3);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // Press lands on the clearing read edge: set wins.
        btn2 = 1'b1;
        repeat (5) @(negedge clk);
        address     = 8'd0;
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        check("collide_read", data_out, 32'h0);
        check("collide_irq", {31'b0, irq}, 32'h1);
        do_read(8'd0, rd); check("collide_next_read", rd, 32'h2);
        btn2 = 1'b0;
        repeat (10) @(negedge clk);
        check("collide_irq_off", {31'b0, irq}, 32'h0);

        // Simultaneous read and write returns the old value.
        @(negedge clk);
        address = 8'd2; data_in = 32'h1; read_enable = 1'b1; write_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0; write_enable = 1'b0;
        check("rw_old_value", data_out, 32'h2);
        do_read(8'd2, rd); check("rw_new_value", rd, 32'h1);

        // Counter saturation, preloaded near the limit.
        force dut.count1_q = 16'hFFFE;
        @(negedge clk);
        release dut.count1_q;
        press(1, 10);
        do_read(8'd3, rd); check("count_sat_reach", rd, 32'h0002_FFFF);
        press(1, 10);
        do_read(8'd3, rd); check("count_sat_hold", rd, 32'h0002_FFFF);
        do_write(8'd3, 32'h1234_5678);
        do_read(8'd3, rd); check("count_write_clear", rd, 32'h0);

        // Unmapped address and IRQ_EN width.
        do_write(8'd7, 32'hFFFF_FFFF);
        do_read(8'd7, rd); check("unmapped_read", rd, 32'h0);
        do_read(8'd2, rd); check("unmapped_no_effect", rd, 32'h1);
        do_write(8'd2, 32'hFFFF_FFFF);
        do_read(8'd2, rd); check("irq_en_width", rd, 32'h3);
        do_read(8'd0, rd); check("final_event", rd, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
